mmio_gpio: RTL and testbench

- Parametrised memory-mapped GPIO peripheral; successor to the single 4-bit write-only LED register in the soc top.
- Provides WIDTH channels, each with per-bit direction, atomic set/clear/toggle, and a synchronised input path.
- Detects rising and falling edges per channel and drives a level interrupt.
- Sits on the CPU data bus behind the soc address decoder, which drives sel.

---
 rtl/mmio_gpio_pkg.sv | 16 +
 rtl/mmio_gpio_sync.sv | 19 +
 rtl/mmio_gpio.sv | 77 +++++++
 tb/tb_mmio_gpio.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_gpio_pkg.sv
// mmio_gpio_pkg: register byte offsets within the GPIO window and the byte-lane write mask shared with the soc decoder
package mmio_gpio_pkg;
  localparam logic [5:0] GPIO_OUT   = 6'h00;
  localparam logic [5:0] GPIO_SET   = 6'h04;
  localparam logic [5:0] GPIO_CLR   = 6'h08;
  localparam logic [5:0] GPIO_TGL   = 6'h0C;
  localparam logic [5:0] GPIO_DIR   = 6'h10;
  localparam logic [5:0] GPIO_IN    = 6'h14;
  localparam logic [5:0] GPIO_RISE  = 6'h18;
  localparam logic [5:0] GPIO_FALL  = 6'h1C;
  localparam logic [5:0] GPIO_PEND  = 6'h20;
  localparam logic [5:0] GPIO_IRQEN = 6'h24;
  function automatic logic [31:0] lane_mask(input logic [3:0] wen);
    return {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  endfunction
endpackage

// File: rtl/mmio_gpio_sync.sv
// sync_chain: STAGES-deep flop chain per bit taking async d (WIDTH) to q on clk, async active-low rst_n clears every stage
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r [STAGES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < STAGES; i++) r[i] <= '0;
    else begin
      r[0] <= d;
      for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
    end
  assign q = r[STAGES-1];
endmodule

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO (clk, rst_n, bus sel/addr/wen/wdata/rdata, pads gpio_in/gpio_out/gpio_oe, level irq) with set/clr/tgl, synchronised inputs and rw1c edge capture
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [5:0]       addr,
  input  logic [3:0]       wen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [WIDTH-1:0] out_r, dir_r, rise_en, fall_en, pend, irq_en, sync_in, prev, ev, mw, bm, clr, rd;
  logic [31:0] m;
  logic [5:0] a;
  logic we, unused_ok;
  sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(gpio_in), .q(sync_in));
  assign a = {addr[5:2], 2'b00};
  assign we = sel && |wen;
  assign m = lane_mask(wen);
  assign mw = m[WIDTH-1:0];
  assign bm = wdata[WIDTH-1:0] & mw;
  assign clr = (we && a == GPIO_PEND) ? bm : '0;
  assign ev = (sync_in & ~prev & rise_en) | (~sync_in & prev & fall_en);
  assign unused_ok = ^{addr[1:0], wdata, m};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_r <= OUT_RESET;
      dir_r <= DIR_RESET;
      rise_en <= '0;
      fall_en <= '0;
      irq_en <= '0;
      pend <= '0;
      prev <= '0;
    end else begin
      prev <= sync_in;
      pend <= (pend & ~clr) | ev;
      if (we)
        case (a)
          GPIO_OUT:   out_r <= (out_r & ~mw) | bm;
          GPIO_SET:   out_r <= out_r | bm;
          GPIO_CLR:   out_r <= out_r & ~bm;
          GPIO_TGL:   out_r <= out_r ^ bm;
          GPIO_DIR:   dir_r <= (dir_r & ~mw) | bm;
          GPIO_RISE:  rise_en <= (rise_en & ~mw) | bm;
          GPIO_FALL:  fall_en <= (fall_en & ~mw) | bm;
          GPIO_IRQEN: irq_en <= (irq_en & ~mw) | bm;
          default: ;
        endcase
    end
  always_comb begin
    rd = '0;
    case (a)
      GPIO_OUT:   rd = out_r;
      GPIO_DIR:   rd = dir_r;
      GPIO_IN:    rd = sync_in;
      GPIO_RISE:  rd = rise_en;
      GPIO_FALL:  rd = fall_en;
      GPIO_PEND:  rd = pend;
      GPIO_IRQEN: rd = irq_en;
      default:    rd = '0;
    endcase
  end
  assign rdata = sel ? 32'(rd) : '0;
  assign gpio_out = out_r;
  assign gpio_oe = dir_r;
  assign irq = |(pend & irq_en);
endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: directed and randomized checks of a 4-bit and a 32-bit mmio_gpio against a behavioural register/pad-history model
module tb_mmio_gpio;
  import mmio_gpio_pkg::*;
  logic clk = 0, rst_n = 0, sel = 0;
  logic [5:0] addr = '0;
  logic [3:0] wen = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd4, rd32, gi32 = '0, go32, oe32;
  logic [3:0] gi4 = '0, go4, oe4;
  logic irq4, irq32;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_out[2], m_dir[2], m_ren[2], m_fen[2], m_pend[2], m_ien[2];
  logic [31:0] hist[2][3];
  always #5 clk = ~clk;
  mmio_gpio u4 (.clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wen(wen), .wdata(wdata), .rdata(rd4),
    .gpio_in(gi4), .gpio_out(go4), .gpio_oe(oe4), .irq(irq4));
  mmio_gpio #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wen(wen), .wdata(wdata), .rdata(rd32),
    .gpio_in(gi32), .gpio_out(go32), .gpio_oe(oe32), .irq(irq32));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] wm(int i);
    return i == 1 ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_dir[i] = wm(i); m_ren[i] = 0; m_fen[i] = 0; m_pend[i] = 0; m_ien[i] = 0;
      for (int k = 0; k < 3; k++) hist[i][k] = 0;
    end
  endtask
  function automatic logic [31:0] m_read(int i, logic [5:0] a);
    case (a[5:2])
      4'h0: return m_out[i];
      4'h4: return m_dir[i];
      4'h5: return hist[i][1];
      4'h6: return m_ren[i];
      4'h7: return m_fen[i];
      4'h8: return m_pend[i];
      4'h9: return m_ien[i];
      default: return 0;
    endcase
  endfunction
  // hist[i][0] is the newest pad sample, [1] the synchronised IN value, [2] the previous IN value
  task automatic m_step();
    logic [31:0] lm, b, ev, clr;
    lm = lane_mask(wen);
    for (int i = 0; i < 2; i++) begin
      ev = ((hist[i][1] & ~hist[i][2] & m_ren[i]) | (~hist[i][1] & hist[i][2] & m_fen[i])) & wm(i);
      clr = 0;
      b = wdata & lm & wm(i);
      if (sel && wen != 0)
        case (addr[5:2])
          4'h0: m_out[i] = (m_out[i] & ~lm) | b;
          4'h1: m_out[i] = m_out[i] | b;
          4'h2: m_out[i] = m_out[i] & ~b;
          4'h3: m_out[i] = m_out[i] ^ b;
          4'h4: m_dir[i] = (m_dir[i] & ~lm) | b;
          4'h6: m_ren[i] = (m_ren[i] & ~lm) | b;
          4'h7: m_fen[i] = (m_fen[i] & ~lm) | b;
          4'h8: clr = b;
          4'h9: m_ien[i] = (m_ien[i] & ~lm) | b;
          default: ;
        endcase
      m_pend[i] = (m_pend[i] & ~clr) | ev;
      hist[i][2] = hist[i][1];
      hist[i][1] = hist[i][0];
      hist[i][0] = i == 1 ? gi32 : 32'(gi4);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] w);
    sel = 1; addr = a; wdata = d; wen = w;
    tick();
    sel = 0; wen = 0;
  endtask
  task automatic chk_rd(input string tag, input logic [5:0] a);
    sel = 1; wen = 0; addr = a;
    #1;
    check({tag, "_rd4"}, rd4, m_read(0, a));
    check({tag, "_rd32"}, rd32, m_read(1, a));
    sel = 0;
  endtask
  task automatic check_all(input string tag);
    check({tag, "_out4"}, 32'(go4), m_out[0]);
    check({tag, "_oe4"}, 32'(oe4), m_dir[0]);
    check({tag, "_irq4"}, 32'(irq4), 32'(|(m_pend[0] & m_ien[0])));
    check({tag, "_out32"}, go32, m_out[1]);
    check({tag, "_oe32"}, oe32, m_dir[1]);
    check({tag, "_irq32"}, 32'(irq32), 32'(|(m_pend[1] & m_ien[1])));
  endtask
  task automatic rd_const(input string tag, input logic [5:0] a, input logic [31:0] e4);
    sel = 1; wen = 0; addr = a;
    #1;
    check(tag, rd4, e4);
    sel = 0;
  endtask
  initial begin
    m_reset();
    #12;
    check("rst_out", 32'(go4), 32'h0);
    check("rst_oe", 32'(oe4), 32'hF);
    check("rst_irq", 32'(irq4), 32'h0);
    for (int k = 0; k < 16; k++) begin
      sel = 1; addr = 6'(k * 4);
      #1;
      check("rst_rd4", rd4, k == 4 ? 32'hF : 32'h0);
      check("rst_rd32", rd32, k == 4 ? 32'hFFFF_FFFF : 32'h0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1;
    wr(GPIO_OUT, 32'hAABB_CCDD, 4'b1111);
    wr(GPIO_OUT, 32'h1122_3344, 4'b0101);
    sel = 1; addr = GPIO_OUT; #1;
    check("lanes32", rd32, 32'hAA22_CC44);
    sel = 0;
    chk_rd("lanes", GPIO_OUT);
    wr(GPIO_OUT, 32'h5, 4'b1111);
    wr(GPIO_SET, 32'h2, 4'b1111);
    check("set", 32'(go4), 32'h7);
    wr(GPIO_CLR, 32'h1, 4'b1111);
    check("clr", 32'(go4), 32'h6);
    wr(GPIO_TGL, 32'hC, 4'b1111);
    check("tgl", 32'(go4), 32'hA);
    rd_const("rd_tgl", GPIO_TGL, 32'h0);
    check_all("atomic");
    wr(GPIO_RISE, 32'h1, 4'b1111);
    wr(GPIO_IRQEN, 32'h1, 4'b1111);
    gi4 = 4'h1;
    tick();
    rd_const("in_1edge", GPIO_IN, 32'h0);
    tick();
    rd_const("in_2edge", GPIO_IN, 32'h1);
    rd_const("pend_2edge", GPIO_PEND, 32'h0);
    check("irq_2edge", 32'(irq4), 32'h0);
    tick();
    rd_const("pend_3edge", GPIO_PEND, 32'h1);
    check("irq_3edge", 32'(irq4), 32'h1);
    gi4 = 4'h0;
    tick(); tick(); tick();
    rd_const("fall_gated", GPIO_PEND, 32'h1);
    check_all("sync");
    gi4 = 4'h1;
    tick(); tick();
    wr(GPIO_PEND, 32'h1, 4'b1111);
    rd_const("w1c_race", GPIO_PEND, 32'h1);
    wr(GPIO_PEND, 32'h1, 4'b1111);
    rd_const("w1c_clear", GPIO_PEND, 32'h0);
    check("w1c_irq", 32'(irq4), 32'h0);
    sel = 0; addr = GPIO_OUT; wen = 4'b1111; wdata = 32'hFFFF_FFFF;
    tick();
    check("nosel_out", 32'(go4), 32'hA);
    #1;
    check("nosel_rd", rd4, 32'h0);
    wen = 0;
    rd_const("unmapped", 6'h2C, 32'h0);
    check_all("decode");
    for (int it = 0; it < 600; it++) begin
      sel = ($urandom % 4) != 0;
      addr = 6'($urandom);
      wen = 4'($urandom);
      wdata = $urandom;
      if ($urandom % 3 == 0) gi4 = 4'($urandom);
      if ($urandom % 4 == 0) gi32 = $urandom;
      tick();
      sel = 0; wen = 0;
      check_all("rand");
      chk_rd("rand", 6'($urandom));
      if (it == 300) begin
        #2;
        rst_n = 0;
        m_reset();
        #1;
        check_all("midrst");
        @(negedge clk);
        rst_n = 1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
